// File: rtl/l2req_arbiter_mux.sv
// l2req_arbiter_mux: three-source round-robin arbiter and request mux in front
// of the L2. Arbitration and the data mux are combinational (zero latency).
// A source that wins but is not acked is locked in until its ack arrives.
module l2req_arbiter_mux (
   input  logic         clk,
   input  logic         reset,
   input  logic         l2req_ack,

   input  logic         icache_l2req_valid,
   input  logic [1:0]   icache_l2req_strand,
   input  logic [1:0]   icache_l2req_unit,
   input  logic [2:0]   icache_l2req_op,
   input  logic [1:0]   icache_l2req_way,
   input  logic [25:0]  icache_l2req_address,
   input  logic [511:0] icache_l2req_data,
   input  logic [63:0]  icache_l2req_mask,

   input  logic         dcache_l2req_valid,
   input  logic [1:0]   dcache_l2req_strand,
   input  logic [1:0]   dcache_l2req_unit,
   input  logic [2:0]   dcache_l2req_op,
   input  logic [1:0]   dcache_l2req_way,
   input  logic [25:0]  dcache_l2req_address,
   input  logic [511:0] dcache_l2req_data,
   input  logic [63:0]  dcache_l2req_mask,

   input  logic         stbuf_l2req_valid,
   input  logic [1:0]   stbuf_l2req_strand,
   input  logic [1:0]   stbuf_l2req_unit,
   input  logic [2:0]   stbuf_l2req_op,
   input  logic [1:0]   stbuf_l2req_way,
   input  logic [25:0]  stbuf_l2req_address,
   input  logic [511:0] stbuf_l2req_data,
   input  logic [63:0]  stbuf_l2req_mask,

   output logic         l2req_valid,
   output logic [1:0]   l2req_strand,
   output logic [1:0]   l2req_unit,
   output logic [2:0]   l2req_op,
   output logic [1:0]   l2req_way,
   output logic [25:0]  l2req_address,
   output logic [511:0] l2req_data,
   output logic [63:0]  l2req_mask,

   output logic         icache_l2req_selected,
   output logic         dcache_l2req_selected,
   output logic         stbuf_l2req_selected
);

   typedef enum logic [1:0] {
      GNT_NONE   = 2'd0,
      GNT_ICACHE = 2'd1,
      GNT_DCACHE = 2'd2,
      GNT_STBUF  = 2'd3
   } grant_e;

   typedef enum logic [1:0] {
      PTR_ICACHE = 2'd0,
      PTR_DCACHE = 2'd1,
      PTR_STBUF  = 2'd2
   } ptr_e;

   grant_e grant_q, grant_d, winner;
   ptr_e   ptr_q, ptr_d;

   // Pick the winner: a locked grant wins outright, else round-robin from the pointer.
   always_comb begin
      winner = GNT_NONE;
      if (grant_q != GNT_NONE) begin
         winner = grant_q;
      end else begin
         case (ptr_q)
            PTR_ICACHE: begin
               if (icache_l2req_valid)      winner = GNT_ICACHE;
               else if (dcache_l2req_valid) winner = GNT_DCACHE;
               else if (stbuf_l2req_valid)  winner = GNT_STBUF;
            end
            PTR_DCACHE: begin
               if (dcache_l2req_valid)      winner = GNT_DCACHE;
               else if (stbuf_l2req_valid)  winner = GNT_STBUF;
               else if (icache_l2req_valid) winner = GNT_ICACHE;
            end
            default: begin
               if (stbuf_l2req_valid)       winner = GNT_STBUF;
               else if (icache_l2req_valid) winner = GNT_ICACHE;
               else if (dcache_l2req_valid) winner = GNT_DCACHE;
            end
         endcase
      end
   end

   // Present the winner's fields unmodified; everything is zero with no winner.
   always_comb begin
      l2req_valid           = 1'b0;
      l2req_strand          = '0;
      l2req_unit            = '0;
      l2req_op              = '0;
      l2req_way             = '0;
      l2req_address         = '0;
      l2req_data            = '0;
      l2req_mask            = '0;
      icache_l2req_selected = 1'b0;
      dcache_l2req_selected = 1'b0;
      stbuf_l2req_selected  = 1'b0;
      case (winner)
         GNT_ICACHE: begin
            l2req_valid           = 1'b1;
            icache_l2req_selected = 1'b1;
            l2req_strand          = icache_l2req_strand;
            l2req_unit            = icache_l2req_unit;
            l2req_op              = icache_l2req_op;
            l2req_way             = icache_l2req_way;
            l2req_address         = icache_l2req_address;
            l2req_data            = icache_l2req_data;
            l2req_mask            = icache_l2req_mask;
         end
         GNT_DCACHE: begin
            l2req_valid           = 1'b1;
            dcache_l2req_selected = 1'b1;
            l2req_strand          = dcache_l2req_strand;
            l2req_unit            = dcache_l2req_unit;
            l2req_op              = dcache_l2req_op;
            l2req_way             = dcache_l2req_way;
            l2req_address         = dcache_l2req_address;
            l2req_data            = dcache_l2req_data;
            l2req_mask            = dcache_l2req_mask;
         end
         GNT_STBUF: begin
            l2req_valid           = 1'b1;
            stbuf_l2req_selected  = 1'b1;
            l2req_strand          = stbuf_l2req_strand;
            l2req_unit            = stbuf_l2req_unit;
            l2req_op              = stbuf_l2req_op;
            l2req_way             = stbuf_l2req_way;
            l2req_address         = stbuf_l2req_address;
            l2req_data            = stbuf_l2req_data;
            l2req_mask            = stbuf_l2req_mask;
         end
         default: ;
      endcase
   end

   // Lock an unacked winner; on ack release the lock and advance the pointer past it.
   always_comb begin
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if (winner != GNT_NONE) begin
         if (l2req_ack) begin
            grant_d = GNT_NONE;
            case (winner)
               GNT_ICACHE: ptr_d = PTR_DCACHE;
               GNT_DCACHE: ptr_d = PTR_STBUF;
               default:    ptr_d = PTR_ICACHE;
            endcase
         end else begin
            grant_d = winner;
         end
      end
   end

   // Grant and pointer registers; reset drops any lock and restarts at icache.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q <= GNT_NONE;
         ptr_q   <= PTR_ICACHE;
      end else begin
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_l2req_arbiter_mux.sv
// Bench for l2req_arbiter_mux: a directed vector table followed by random
// traffic checked against a small arbitration model.
module tb_l2req_arbiter_mux;

   localparam logic [2:0] IC = 3'b001;
   localparam logic [2:0] DC = 3'b010;
   localparam logic [2:0] SB = 3'b100;
   localparam int W_NONE = -1;
   localparam int W_IC   = 0;
   localparam int W_DC   = 1;
   localparam int W_SB   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         ack;
   logic [2:0]   vld;          // bit 0 icache, bit 1 dcache, bit 2 stbuf
   logic [610:0] fld [3];      // {strand,unit,op,way,address,data,mask} per source

   logic         o_valid;
   logic [1:0]   o_strand, o_unit, o_way;
   logic [2:0]   o_op;
   logic [25:0]  o_address;
   logic [511:0] o_data;
   logic [63:0]  o_mask;
   logic         sel_ic, sel_dc, sel_sb;

   l2req_arbiter_mux dut (
      .clk(clk), .reset(reset), .l2req_ack(ack),
      .icache_l2req_valid(vld[0]), .icache_l2req_strand(fld[0][610:609]),
      .icache_l2req_unit(fld[0][608:607]), .icache_l2req_op(fld[0][606:604]),
      .icache_l2req_way(fld[0][603:602]), .icache_l2req_address(fld[0][601:576]),
      .icache_l2req_data(fld[0][575:64]), .icache_l2req_mask(fld[0][63:0]),
      .dcache_l2req_valid(vld[1]), .dcache_l2req_strand(fld[1][610:609]),
      .dcache_l2req_unit(fld[1][608:607]), .dcache_l2req_op(fld[1][606:604]),
      .dcache_l2req_way(fld[1][603:602]), .dcache_l2req_address(fld[1][601:576]),
      .dcache_l2req_data(fld[1][575:64]), .dcache_l2req_mask(fld[1][63:0]),
      .stbuf_l2req_valid(vld[2]), .stbuf_l2req_strand(fld[2][610:609]),
      .stbuf_l2req_unit(fld[2][608:607]), .stbuf_l2req_op(fld[2][606:604]),
      .stbuf_l2req_way(fld[2][603:602]), .stbuf_l2req_address(fld[2][601:576]),
      .stbuf_l2req_data(fld[2][575:64]), .stbuf_l2req_mask(fld[2][63:0]),
      .l2req_valid(o_valid), .l2req_strand(o_strand), .l2req_unit(o_unit),
      .l2req_op(o_op), .l2req_way(o_way), .l2req_address(o_address),
      .l2req_data(o_data), .l2req_mask(o_mask),
      .icache_l2req_selected(sel_ic), .dcache_l2req_selected(sel_dc),
      .stbuf_l2req_selected(sel_sb)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: lock holder (-1 = none) and round-robin start index.
   int m_grant = -1;
   int m_ptr   = 0;

   function automatic int model_winner(logic [2:0] v);
      if (m_grant >= 0) return m_grant;
      for (int k = 0; k < 3; k++) begin
         int s;
         s = (m_ptr + k) % 3;
         if (v[s]) return s;
      end
      return -1;
   endfunction

   task automatic model_update(bit r, logic [2:0] v, bit a);
      int w;
      w = model_winner(v);
      if (r) begin
         m_grant = -1;
         m_ptr   = 0;
      end else if (w >= 0) begin
         if (a) begin
            m_grant = -1;
            m_ptr   = (w + 1) % 3;
         end else begin
            m_grant = w;
         end
      end
   endtask

   function automatic logic [610:0] rnd_fld();
      logic [610:0] r;
      r = '0;
      for (int i = 0; i < 20; i++) r = {r[578:0], $urandom()};
      return r;
   endfunction

   task automatic check_out(string nm, int exp_w);
      logic [3:0]   exp_ctl, got_ctl;
      logic [610:0] exp_bus, got_bus;
      exp_ctl = (exp_w < 0) ? 4'b0000 : {1'b1, 3'(3'b001 << exp_w)};
      got_ctl = {o_valid, sel_sb, sel_dc, sel_ic};
      exp_bus = (exp_w < 0) ? '0 : fld[exp_w];
      got_bus = {o_strand, o_unit, o_op, o_way, o_address, o_data, o_mask};
      checks++;
      if (got_ctl !== exp_ctl) begin
         errors++;
         $display("FAIL %s ctl {valid,sb,dc,ic}: got %b want %b", nm, got_ctl, exp_ctl);
      end
      checks++;
      if (got_bus !== exp_bus) begin
         errors++;
         $display("FAIL %s fields: got %h want %h", nm, got_bus, exp_bus);
      end
   endtask

   // One clock cycle: drive at the falling edge, check just after, clock in at the rising edge.
   task automatic run_cycle(string nm, bit r, logic [2:0] v, bit a, int exp_w);
      @(negedge clk);
      reset = r;
      vld   = v;
      ack   = a;
      for (int i = 0; i < 3; i++) fld[i] = rnd_fld();
      #1;
      check_out(nm, exp_w);
      model_update(r, v, a);
   endtask

   typedef struct {
      string      nm;
      bit         rst;
      logic [2:0] v;
      bit         ack;
      int         exp_w;
   } vec_t;

   vec_t tbl [21];

   initial begin
      reset = 1'b1;
      ack   = 1'b0;
      vld   = '0;
      for (int i = 0; i < 3; i++) fld[i] = '0;

      tbl[0]  = '{"reset_state",   1'b1, 3'b000,       1'b0, W_NONE};
      tbl[1]  = '{"ack_no_winner", 1'b0, 3'b000,       1'b1, W_NONE};
      tbl[2]  = '{"rr_ic",         1'b0, IC|DC|SB,     1'b1, W_IC};
      tbl[3]  = '{"rr_dc",         1'b0, IC|DC|SB,     1'b1, W_DC};
      tbl[4]  = '{"rr_sb",         1'b0, IC|DC|SB,     1'b1, W_SB};
      tbl[5]  = '{"rr_ic_again",   1'b0, IC|DC|SB,     1'b1, W_IC};
      tbl[6]  = '{"dc_hold_1",     1'b0, DC,           1'b0, W_DC};
      tbl[7]  = '{"dc_hold_2",     1'b0, IC|DC,        1'b0, W_DC};
      tbl[8]  = '{"dc_hold_ack",   1'b0, IC|DC,        1'b1, W_DC};
      tbl[9]  = '{"ic_after_dc",   1'b0, IC,           1'b1, W_IC};
      tbl[10] = '{"sb_acked",      1'b0, SB,           1'b1, W_SB};
      tbl[11] = '{"wrap_to_ic",    1'b0, IC|SB,        1'b1, W_IC};
      tbl[12] = '{"sb_lock",       1'b0, SB,           1'b0, W_SB};
      tbl[13] = '{"sb_drop_valid", 1'b0, 3'b000,       1'b0, W_SB};
      tbl[14] = '{"sb_lock_ack",   1'b0, IC|DC,        1'b1, W_SB};
      tbl[15] = '{"ic_first",      1'b0, IC,           1'b1, W_IC};
      tbl[16] = '{"ic_lock",       1'b0, IC,           1'b0, W_IC};
      tbl[17] = '{"reset_locked",  1'b1, IC|DC,        1'b1, W_IC};
      tbl[18] = '{"post_reset",    1'b0, IC|DC,        1'b0, W_IC};
      tbl[19] = '{"post_reset_ack",1'b0, IC|DC,        1'b1, W_IC};
      tbl[20] = '{"next_dc",       1'b0, IC|DC,        1'b1, W_DC};

      // Initial reset edge to define state before any check.
      @(posedge clk);
      m_grant = -1;
      m_ptr   = 0;

      for (int i = 0; i < 21; i++)
         run_cycle(tbl[i].nm, tbl[i].rst, tbl[i].v, tbl[i].ack, tbl[i].exp_w);

      // Random traffic with occasional resets against the model.
      for (int n = 0; n < 600; n++) begin
         bit         r, a;
         logic [2:0] v;
         r = ($urandom_range(0, 49) == 0);
         v = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 1) == 1);
         run_cycle("rand", r, v, a, model_winner(v));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/l2req_arbiter_mux.md
L2REQ_ARBITER_MUX -- requirements
Module: l2req_arbiter_mux

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 l2req_ack  in  1  L2 accepts the request currently presented on l2req_*.
REQ-005 Each source X in {icache, dcache, stbuf} SHALL provide these inputs: X_l2req_valid (1), X_l2req_strand (2), X_l2req_unit (2), X_l2req_op (3), X_l2req_way (2), X_l2req_address (26), X_l2req_data (512), X_l2req_mask (64).
REQ-006 Outputs to L2: l2req_valid (1), l2req_strand (2), l2req_unit (2), l2req_op (3), l2req_way (2), l2req_address (26), l2req_data (512), l2req_mask (64).
REQ-007 Outputs icache_l2req_selected, dcache_l2req_selected, stbuf_l2req_selected (1 each) SHALL identify the source currently driving l2req_*; the integrator gates each source's ack as l2req_ack AND X_l2req_selected.

Function
REQ-008 SHALL hold two registers: grant (NONE/ICACHE/DCACHE/STBUF) and a round-robin pointer (ICACHE/DCACHE/STBUF).
REQ-009 With grant=NONE, the winner SHALL be picked combinationally among asserted valids, searching from the pointer in the fixed order icache -> dcache -> stbuf -> icache.
REQ-010 With grant!=NONE, the winner SHALL be the granted source regardless of the other valids (a lock-until-ack rule).
REQ-011 l2req_valid SHALL equal 1 whenever a winner exists, in the same cycle (zero added latency); it is 0 otherwise.
REQ-012 l2req_strand/unit/op/way/address/data/mask SHALL be a combinational mux of the winner's fields, passed through unmodified; all fields SHALL be 0 when there is no winner.
REQ-013 Exactly one *_selected SHALL be 1 when a winner exists (the winner's); all three SHALL be 0 otherwise.
REQ-014 A winner with l2req_ack=0 at the clock edge SHALL load grant with that winner.
REQ-015 l2req_ack=1 at the clock edge SHALL set grant to NONE and set the pointer to the source after the winner (icache->dcache, dcache->stbuf, stbuf->icache).
REQ-016 The pointer SHALL change only on an acked transfer.
REQ-017 An ack in the first cycle of a request (grant=NONE) SHALL complete that request with no grant cycle.
REQ-018 After an ack, the next cycle SHALL re-arbitrate immediately; back-to-back grants are allowed with no bubble.
REQ-019 A source deasserting valid while granted is a protocol violation; the arbiter SHALL keep presenting its fields and keep l2req_valid=1 until ack, with no checking.
REQ-020 l2req_ack with no winner SHALL be ignored: no state change.
REQ-021 Simultaneous valids: only the winner is presented, and losers wait with no loss.
REQ-022 With all three sources continuously requesting, service SHALL rotate strictly; no source waits more than two other transfers.

Reset
REQ-023 reset=1 at a clock edge SHALL set grant=NONE and pointer=ICACHE, overriding any ack or valid in that cycle.
REQ-024 reset does not gate the combinational outputs: during reset, outputs follow REQ-009..REQ-013 from the reset/current state.
REQ-025 A request pending when reset is applied SHALL be dropped from grant and re-arbitrated from pointer=ICACHE after reset.

Verification
REQ-026 After reset, all three valids=1 with ack=1 each cycle -> selected order icache, dcache, stbuf, icache; l2req_valid=1 every cycle.
REQ-027 dcache alone valid (address=26'h155, op=3'd2, mask=64'hFF), ack held 0 for 3 cycles -> dcache_l2req_selected=1 and fields stable for all 3 cycles; icache raising valid in cycle 2 is not selected until after the ack.
REQ-028 No valids, ack=1 -> l2req_valid=0, all selected=0, all fields 0; pointer unchanged (icache still wins first afterwards).
REQ-029 stbuf acked, then icache and stbuf both valid -> icache wins (pointer wrapped to ICACHE).
REQ-030 icache granted (ack=0), reset pulsed with dcache and icache valid -> post-reset grant=NONE, icache wins from pointer=ICACHE.
